// File: rtl/cpu_ma_lsu_pkg.sv
// cpu_common: shared pipeline types and helpers used by the memory access stage.
//   ma_mode_t   - memory access mode (none / load / store)
//   ma_size_t   - access size (byte / half / word)
//   wb_src_t    - write-back source select
//   lsu_state_t - load/store unit FSM states
//   NOP_PC/NOP_IR - values that mark a pipeline bubble
package cpu_common;

    typedef enum logic [1:0] {
        MA_X     = 2'd0,
        MA_LOAD  = 2'd1,
        MA_STORE = 2'd2
    } ma_mode_t;

    typedef enum logic [1:0] {
        MA_SIZE_B = 2'd0,
        MA_SIZE_H = 2'd1,
        MA_SIZE_W = 2'd2
    } ma_size_t;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MEM = 2'd1,
        WB_SRC_PC  = 2'd2,
        WB_SRC_CSR = 2'd3
    } wb_src_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ0 = 2'd1,
        LSU_REQ1 = 2'd2
    } lsu_state_t;

    localparam logic [31:0] NOP_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_IR = 32'h0000_0013;

    // Number of bytes moved by an access of the given size.
    function automatic logic [2:0] ma_size_bytes(input ma_size_t size);
        case (size)
            MA_SIZE_B: return 3'd1;
            MA_SIZE_H: return 3'd2;
            MA_SIZE_W: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic ma_misaligned(input logic [1:0] offset, input ma_size_t size);
        case (size)
            MA_SIZE_B: return 1'b0;
            MA_SIZE_H: return offset[0];
            MA_SIZE_W: return |offset;
            default:   return |offset;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ma_lsu_align.sv
// cpu_lsu_align: combinational lane alignment for the memory access stage.
//   offset_i/size_i/unsigned_i - byte offset, size and extension of the access
//   store_data_i  -> store_data_o : store data rotated into its byte lanes
//   mask0_o/mask1_o               : byte enables for the first / second word beat
//   split_o                       : access crosses a word boundary
//   beat0_i/beat1_i -> load_data_o: merged, truncated and extended load value
module cpu_lsu_align
    import cpu_common::*;
(
    input  logic [1:0]  offset_i,
    input  ma_size_t    size_i,
    input  logic        unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] beat0_i,
    input  logic [31:0] beat1_i,
    output logic [31:0] store_data_o,
    output logic [3:0]  mask0_o,
    output logic [3:0]  mask1_o,
    output logic        split_o,
    output logic [31:0] load_data_o
);

    logic [2:0]  bytes_s;
    logic [2:0]  end_lane_s;
    logic [4:0]  shamt_s;
    logic [31:0] merged_s;
    logic        sign_s;

    // Lane masks, store rotation and load merge/extension.
    always_comb begin
        bytes_s    = ma_size_bytes(size_i);
        // Last byte lane touched, counted across both words (4..6 means beat 1).
        end_lane_s = {1'b0, offset_i} + bytes_s - 3'd1;
        split_o    = ({1'b0, offset_i} + bytes_s) > 3'd4;
        for (int i = 0; i < 4; i++) begin
            mask0_o[i] = (3'(i) >= {1'b0, offset_i}) && (3'(i) <= end_lane_s);
            mask1_o[i] = split_o && ((3'(i) + 3'd4) <= end_lane_s);
        end
        shamt_s      = {offset_i, 3'b000};
        // A shift by 32 yields zero, so offset 0 degenerates to the plain value.
        store_data_o = (store_data_i << shamt_s) | (store_data_i >> (6'd32 - {1'b0, shamt_s}));
        merged_s     = 32'({beat1_i, beat0_i} >> shamt_s);
        sign_s       = !unsigned_i;
        case (size_i)
            MA_SIZE_B: load_data_o = {{24{sign_s & merged_s[7]}}, merged_s[7:0]};
            MA_SIZE_H: load_data_o = {{16{sign_s & merged_s[15]}}, merged_s[15:0]};
            MA_SIZE_W: load_data_o = merged_s;
            default:   load_data_o = merged_s;
        endcase
    end

endmodule

// File: rtl/cpu_ma_lsu.sv
// cpu_ma_lsu: memory access stage between EX and WB with a req/ack data port.
//   valid_i/ready_o          : upstream handshake, ready low stalls EX
//   pc_i..wb_valid_i         : instruction fields from EX
//   dmem_*                   : variable-latency word memory port
//   *_async_o                : bypass view of the instruction held in this stage
//   pc_o/ir_o/wb_data_o/wb_valid_o/fault_o : registered result towards WB
module cpu_ma_lsu
    import cpu_common::*;
#(
    parameter int ALLOW_MISALIGNED = 1,
    parameter int TIMEOUT_CYCLES   = 256
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] pc_i,
    input  logic [31:0] ir_i,
    input  logic [31:0] ma_addr_i,
    input  logic [31:0] ma_data_i,
    input  logic [31:0] wb_data_i,
    input  ma_mode_t    ma_mode_i,
    input  ma_size_t    ma_size_i,
    input  logic        ma_unsigned_i,
    input  wb_src_t     wb_src_i,
    input  logic        wb_valid_i,
    output logic        dmem_req_o,
    input  logic        dmem_ack_i,
    output logic        dmem_write_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_write_data_o,
    output logic [3:0]  dmem_write_mask_o,
    input  logic [31:0] dmem_read_data_i,
    output logic [4:0]  wb_addr_async_o,
    output logic [31:0] wb_data_async_o,
    output logic        wb_ready_async_o,
    output logic        wb_valid_async_o,
    output logic        empty_async_o,
    output logic [31:0] pc_o,
    output logic [31:0] ir_o,
    output logic [31:0] wb_data_o,
    output logic        wb_valid_o,
    output logic        fault_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    lsu_state_t  state_q, state_d;
    logic [31:0] h_pc_q, h_pc_d, h_ir_q, h_ir_d, h_addr_q, h_addr_d;
    logic [31:0] h_data_q, h_data_d, h_wb_data_q, h_wb_data_d;
    ma_mode_t    h_mode_q, h_mode_d;
    ma_size_t    h_size_q, h_size_d;
    logic        h_uns_q, h_uns_d, h_wbv_q, h_wbv_d;
    wb_src_t     h_src_q, h_src_d;
    logic [31:0] beat0_q, beat0_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, wb_data_q, wb_data_d;
    logic        wb_valid_q, wb_valid_d, fault_q, fault_d;

    logic        in_mem_s, in_fault_s, timeout_s, split_s;
    logic [31:0] beat0_s, beat1_s, store_data_s, load_data_s;
    logic [3:0]  mask0_s, mask1_s;

    assign in_mem_s   = valid_i && (ma_mode_i != MA_X);
    assign in_fault_s = (ALLOW_MISALIGNED == 0) && ma_misaligned(ma_addr_i[1:0], ma_size_i);
    // An ack in the same cycle always wins over the timeout.
    assign timeout_s  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !dmem_ack_i;
    assign beat0_s    = (state_q == LSU_REQ0) ? dmem_read_data_i : beat0_q;
    assign beat1_s    = (state_q == LSU_REQ1) ? dmem_read_data_i : 32'h0000_0000;

    cpu_lsu_align u_align (
        .offset_i     (h_addr_q[1:0]),
        .size_i       (h_size_q),
        .unsigned_i   (h_uns_q),
        .store_data_i (h_data_q),
        .beat0_i      (beat0_s),
        .beat1_i      (beat1_s),
        .store_data_o (store_data_s),
        .mask0_o      (mask0_s),
        .mask1_o      (mask1_s),
        .split_o      (split_s),
        .load_data_o  (load_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: begin
                if (in_mem_s && !in_fault_s) state_d = LSU_REQ0;
                else                          state_d = LSU_IDLE;
            end
            LSU_REQ0: begin
                if (dmem_ack_i)     state_d = split_s ? LSU_REQ1 : LSU_IDLE;
                else if (timeout_s) state_d = LSU_IDLE;
                else                state_d = LSU_REQ0;
            end
            LSU_REQ1: begin
                if (dmem_ack_i || timeout_s) state_d = LSU_IDLE;
                else                         state_d = LSU_REQ1;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // Hold registers, timeout counter and result registers.
    always_comb begin
        h_pc_d = h_pc_q; h_ir_d = h_ir_q; h_addr_d = h_addr_q; h_data_d = h_data_q;
        h_wb_data_d = h_wb_data_q; h_mode_d = h_mode_q; h_size_d = h_size_q;
        h_uns_d = h_uns_q; h_src_d = h_src_q; h_wbv_d = h_wbv_q;
        beat0_d = beat0_q;
        cnt_d   = cnt_q;
        // Bubble unless something below produces a result.
        pc_d = NOP_PC; ir_d = NOP_IR; wb_data_d = 32'h0000_0000;
        wb_valid_d = 1'b0; fault_d = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (in_mem_s && in_fault_s) begin
                    pc_d    = pc_i;
                    ir_d    = ir_i;
                    fault_d = 1'b1;
                end else if (in_mem_s) begin
                    h_pc_d = pc_i; h_ir_d = ir_i; h_addr_d = ma_addr_i; h_data_d = ma_data_i;
                    h_wb_data_d = wb_data_i; h_mode_d = ma_mode_i; h_size_d = ma_size_i;
                    h_uns_d = ma_unsigned_i; h_src_d = wb_src_i; h_wbv_d = wb_valid_i;
                    cnt_d = {CNT_W{1'b0}};
                end else if (valid_i) begin
                    pc_d = pc_i; ir_d = ir_i; wb_data_d = wb_data_i; wb_valid_d = wb_valid_i;
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            LSU_REQ0, LSU_REQ1: begin
                if (dmem_ack_i && (state_q == LSU_REQ0) && split_s) begin
                    beat0_d = dmem_read_data_i;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (dmem_ack_i) begin
                    pc_d       = h_pc_q;
                    ir_d       = h_ir_q;
                    wb_data_d  = (h_mode_q == MA_LOAD) ? load_data_s : h_wb_data_q;
                    wb_valid_d = h_wbv_q;
                end else if (timeout_s) begin
                    pc_d    = h_pc_q;
                    ir_d    = h_ir_q;
                    fault_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            h_pc_q <= NOP_PC; h_ir_q <= NOP_IR; h_addr_q <= 32'h0; h_data_q <= 32'h0;
            h_wb_data_q <= 32'h0; h_mode_q <= MA_X; h_size_q <= MA_SIZE_W;
            h_uns_q <= 1'b0; h_src_q <= WB_SRC_ALU; h_wbv_q <= 1'b0;
            beat0_q <= 32'h0; cnt_q <= {CNT_W{1'b0}};
            pc_q <= NOP_PC; ir_q <= NOP_IR; wb_data_q <= 32'h0;
            wb_valid_q <= 1'b0; fault_q <= 1'b0;
        end else begin
            h_pc_q <= h_pc_d; h_ir_q <= h_ir_d; h_addr_q <= h_addr_d; h_data_q <= h_data_d;
            h_wb_data_q <= h_wb_data_d; h_mode_q <= h_mode_d; h_size_q <= h_size_d;
            h_uns_q <= h_uns_d; h_src_q <= h_src_d; h_wbv_q <= h_wbv_d;
            beat0_q <= beat0_d; cnt_q <= cnt_d;
            pc_q <= pc_d; ir_q <= ir_d; wb_data_q <= wb_data_d;
            wb_valid_q <= wb_valid_d; fault_q <= fault_d;
        end
    end

    // FSM outputs: memory port, stall and bypass view.
    always_comb begin
        ready_o           = (state_q == LSU_IDLE);
        // Reset removes the request in the very cycle it is seen.
        dmem_req_o        = (state_q != LSU_IDLE) && !reset_i;
        dmem_write_o      = (h_mode_q == MA_STORE);
        dmem_addr_o       = {h_addr_q[31:2], 2'b00} + ((state_q == LSU_REQ1) ? 32'd4 : 32'd0);
        dmem_write_data_o = store_data_s;
        if (!dmem_req_o)                dmem_write_mask_o = 4'b0000;
        else if (state_q == LSU_REQ1)   dmem_write_mask_o = mask1_s;
        else                            dmem_write_mask_o = mask0_s;
        if (state_q == LSU_IDLE) begin
            wb_addr_async_o  = ir_i[11:7];
            wb_data_async_o  = wb_data_i;
            wb_ready_async_o = (wb_src_i != WB_SRC_MEM);
            wb_valid_async_o = valid_i && wb_valid_i;
            empty_async_o    = !valid_i || (pc_i == NOP_PC);
        end else begin
            wb_addr_async_o  = h_ir_q[11:7];
            wb_data_async_o  = h_wb_data_q;
            wb_ready_async_o = (h_src_q != WB_SRC_MEM);
            wb_valid_async_o = h_wbv_q;
            empty_async_o    = 1'b0;
        end
        pc_o       = pc_q;
        ir_o       = ir_q;
        wb_data_o  = wb_data_q;
        wb_valid_o = wb_valid_q;
        fault_o    = fault_q;
    end

endmodule

// File: tb/tb_cpu_ma_lsu.sv
module tb_cpu_ma_lsu;
    import cpu_common::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i, valid_i, valid_b, ma_unsigned_i, wb_valid_i, ack_a;
    logic [31:0] pc_i, ir_i, ma_addr_i, ma_data_i, wb_data_i, rdata_a;
    ma_mode_t    ma_mode_i;
    ma_size_t    ma_size_i;
    wb_src_t     wb_src_i;

    logic        ready_a, req_a, write_a, wbr_a, wbv_async_a, empty_a, wb_valid_a, fault_a;
    logic [31:0] addr_a, wdata_a, wbd_async_a, pc_a, ir_a, wb_data_a;
    logic [3:0]  mask_a;
    logic [4:0]  wba_a;

    logic        ready_b, req_b, write_b, wbr_b, wbv_async_b, empty_b, wb_valid_b, fault_b;
    logic [31:0] addr_b, wdata_b, wbd_async_b, pc_b, ir_b, wb_data_b;
    logic [3:0]  mask_b;
    logic [4:0]  wba_b;

    cpu_ma_lsu #(.ALLOW_MISALIGNED(1), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_a),
        .pc_i(pc_i), .ir_i(ir_i), .ma_addr_i(ma_addr_i), .ma_data_i(ma_data_i), .wb_data_i(wb_data_i),
        .ma_mode_i(ma_mode_i), .ma_size_i(ma_size_i), .ma_unsigned_i(ma_unsigned_i),
        .wb_src_i(wb_src_i), .wb_valid_i(wb_valid_i),
        .dmem_req_o(req_a), .dmem_ack_i(ack_a), .dmem_write_o(write_a), .dmem_addr_o(addr_a),
        .dmem_write_data_o(wdata_a), .dmem_write_mask_o(mask_a), .dmem_read_data_i(rdata_a),
        .wb_addr_async_o(wba_a), .wb_data_async_o(wbd_async_a), .wb_ready_async_o(wbr_a),
        .wb_valid_async_o(wbv_async_a), .empty_async_o(empty_a),
        .pc_o(pc_a), .ir_o(ir_a), .wb_data_o(wb_data_a), .wb_valid_o(wb_valid_a), .fault_o(fault_a)
    );

    // Second instance with misaligned accesses disabled; its memory acks immediately with zero.
    cpu_ma_lsu #(.ALLOW_MISALIGNED(0), .TIMEOUT_CYCLES(4)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_b), .ready_o(ready_b),
        .pc_i(pc_i), .ir_i(ir_i), .ma_addr_i(ma_addr_i), .ma_data_i(ma_data_i), .wb_data_i(wb_data_i),
        .ma_mode_i(ma_mode_i), .ma_size_i(ma_size_i), .ma_unsigned_i(ma_unsigned_i),
        .wb_src_i(wb_src_i), .wb_valid_i(wb_valid_i),
        .dmem_req_o(req_b), .dmem_ack_i(req_b), .dmem_write_o(write_b), .dmem_addr_o(addr_b),
        .dmem_write_data_o(wdata_b), .dmem_write_mask_o(mask_b), .dmem_read_data_i(32'h0000_0000),
        .wb_addr_async_o(wba_b), .wb_data_async_o(wbd_async_b), .wb_ready_async_o(wbr_b),
        .wb_valid_async_o(wbv_async_b), .empty_async_o(empty_b),
        .pc_o(pc_b), .ir_o(ir_b), .wb_data_o(wb_data_b), .wb_valid_o(wb_valid_b), .fault_o(fault_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] mem [0:1023];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        int w;
        w = int'(a[9:0]) & ~3;
        return {mem[w+3], mem[w+2], mem[w+1], mem[w]};
    endfunction

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_pc"}, pc_a, NOP_PC);
        check_eq({tag, "_ir"}, ir_a, NOP_IR);
        check_eq({tag, "_wbd"}, wb_data_a, 32'h0);
        check_eq({tag, "_wbv"}, {31'd0, wb_valid_a}, 32'd0);
        check_eq({tag, "_fault"}, {31'd0, fault_a}, 32'd0);
        check_eq({tag, "_req"}, {31'd0, req_a}, 32'd0);
        check_eq({tag, "_mask"}, {28'd0, mask_a}, 32'd0);
        check_eq({tag, "_ready"}, {31'd0, ready_a}, 32'd1);
    endtask

    // Non-memory instruction: appears on the outputs one cycle later.
    task automatic alu_op(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] wbd, input logic wbv);
        check_eq("alu_ready", {31'd0, ready_a}, 32'd1);
        valid_i = 1'b1; pc_i = pc; ir_i = ir; wb_data_i = wbd; wb_valid_i = wbv;
        ma_mode_i = MA_X; wb_src_i = WB_SRC_ALU;
        @(negedge clk);
        valid_i = 1'b0;
        check_eq("alu_pc", pc_a, pc);
        check_eq("alu_wbd", wb_data_a, wbd);
        check_eq("alu_wbv", {31'd0, wb_valid_a}, {31'd0, wbv});
        check_eq("alu_fault", {31'd0, fault_a}, 32'd0);
        check_eq("alu_req", {31'd0, req_a}, 32'd0);
    endtask

    // Memory access against a byte-addressed model; wmax bounds wait cycles per beat.
    task automatic mem_op(input ma_mode_t mode, input ma_size_t size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] data, input logic wbv,
                          input logic [31:0] pc, input int wmax);
        int nb, off, nbeats, wt;
        logic [31:0] word0, exp_wdata, exp_res, wbd, ir;
        logic [3:0]  exp_mask;
        longint unsigned v;
        wb_src_t src;
        nb     = (size == MA_SIZE_B) ? 1 : (size == MA_SIZE_H) ? 2 : 4;
        off    = int'(addr[1:0]);
        nbeats = (off + nb > 4) ? 2 : 1;
        word0  = {addr[31:2], 2'b00};
        src    = (mode == MA_LOAD) ? WB_SRC_MEM : WB_SRC_ALU;
        wbd    = $urandom;
        ir     = $urandom;
        for (int l = 0; l < 4; l++) exp_wdata[8*l +: 8] = data[8*((l - off) & 3) +: 8];
        v = 0;
        for (int j = 0; j < nb; j++) v = v | (longint'(mem[int'(addr[9:0]) + j]) << (8*j));
        if (!uns && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
        exp_res = (mode == MA_LOAD) ? v[31:0] : wbd;

        valid_i = 1'b1; pc_i = pc; ir_i = ir; ma_addr_i = addr; ma_data_i = data; wb_data_i = wbd;
        ma_mode_i = mode; ma_size_i = size; ma_unsigned_i = uns; wb_src_i = src; wb_valid_i = wbv;
        @(negedge clk);
        // Garbage upstream while stalled must be ignored.
        pc_i = $urandom; ir_i = $urandom; ma_addr_i = $urandom; wb_data_i = $urandom;
        ma_mode_i = MA_STORE; wb_src_i = WB_SRC_PC;
        check_eq("stall_ready", {31'd0, ready_a}, 32'd0);
        check_eq("stall_bubble", {31'd0, wb_valid_a}, 32'd0);
        check_eq("stall_empty", {31'd0, empty_a}, 32'd0);
        check_eq("stall_wbaddr", {27'd0, wba_a}, {27'd0, ir[11:7]});
        check_eq("stall_wbready", {31'd0, wbr_a}, {31'd0, (src != WB_SRC_MEM)});
        for (int k = 0; k < nbeats; k++) begin
            exp_mask = 4'b0000;
            for (int j = 0; j < nb; j++)
                if (((addr + j) >> 2) == ((addr >> 2) + k)) exp_mask[(addr + j) & 3] = 1'b1;
            wt = $urandom_range(0, wmax);
            for (int c = 0; c <= wt; c++) begin
                check_eq("req", {31'd0, req_a}, 32'd1);
                check_eq("addr", addr_a, word0 + 32'(4*k));
                check_eq("mask", {28'd0, mask_a}, {28'd0, exp_mask});
                check_eq("write", {31'd0, write_a}, {31'd0, (mode == MA_STORE)});
                if (mode == MA_STORE) check_eq("wdata", wdata_a, exp_wdata);
                if (c == wt) begin
                    ack_a = 1'b1;
                    rdata_a = rd_word(word0 + 32'(4*k));
                end
                @(negedge clk);
                ack_a = 1'b0;
                rdata_a = $urandom;
            end
        end
        valid_i = 1'b0;
        check_eq("done_req", {31'd0, req_a}, 32'd0);
        check_eq("done_ready", {31'd0, ready_a}, 32'd1);
        check_eq("done_wbv", {31'd0, wb_valid_a}, {31'd0, wbv});
        check_eq("done_wbd", wb_data_a, exp_res);
        check_eq("done_pc", pc_a, pc);
        check_eq("done_ir", ir_a, ir);
        check_eq("done_fault", {31'd0, fault_a}, 32'd0);
        if (mode == MA_STORE)
            for (int j = 0; j < nb; j++) mem[int'(addr[9:0]) + j] = data[8*j +: 8];
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        reset_i = 1'b1; valid_i = 1'b0; valid_b = 1'b0; ack_a = 1'b0; rdata_a = 32'h0;
        pc_i = 32'h0; ir_i = 32'h0; ma_addr_i = 32'h0; ma_data_i = 32'h0; wb_data_i = 32'h0;
        ma_mode_i = MA_X; ma_size_i = MA_SIZE_W; ma_unsigned_i = 1'b0; wb_src_i = WB_SRC_ALU;
        wb_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        check_reset_values("rst");
        check_eq("idle_empty", {31'd0, empty_a}, 32'd1);

        alu_op(32'h0000_1000, 32'h0010_0093, 32'h1234_5678, 1'b1);

        // Aligned store with immediate ack.
        mem_op(MA_STORE, MA_SIZE_W, 1'b0, 32'h100, 32'hAABB_CCDD, 1'b1, 32'h0000_1004, 0);
        check_eq("sw_mem", rd_word(32'h100), 32'hAABB_CCDD);

        // Split signed half-word load.
        mem[32'h203] = 8'h80; mem[32'h204] = 8'h7F;
        mem_op(MA_LOAD, MA_SIZE_H, 1'b0, 32'h203, 32'h0, 1'b1, 32'h0000_1008, 2);
        check_eq("lh_split", wb_data_a, 32'h0000_7F80);

        // Split store across two words.
        mem_op(MA_STORE, MA_SIZE_W, 1'b0, 32'h102, 32'h1122_3344, 1'b1, 32'h0000_100C, 1);

        // Misaligned access on the instance that faults instead of splitting.
        valid_b = 1'b1; pc_i = 32'h0000_2000; ir_i = 32'h0000_2083; ma_addr_i = 32'h101;
        ma_mode_i = MA_LOAD; ma_size_i = MA_SIZE_W; wb_valid_i = 1'b1; wb_src_i = WB_SRC_MEM;
        #1 check_eq("mis_req_now", {31'd0, req_b}, 32'd0);
        @(negedge clk);
        valid_b = 1'b0;
        check_eq("mis_req", {31'd0, req_b}, 32'd0);
        check_eq("mis_fault", {31'd0, fault_b}, 32'd1);
        check_eq("mis_wbv", {31'd0, wb_valid_b}, 32'd0);
        check_eq("mis_pc", pc_b, 32'h0000_2000);
        valid_b = 1'b1; ma_addr_i = 32'h100;
        @(negedge clk);
        valid_b = 1'b0;
        check_eq("b_aligned_req", {31'd0, req_b}, 32'd1);
        @(negedge clk);
        check_eq("b_aligned_wbv", {31'd0, wb_valid_b}, 32'd1);
        check_eq("b_aligned_fault", {31'd0, fault_b}, 32'd0);

        // Timeout: never ack.
        valid_i = 1'b1; pc_i = 32'h0000_3000; ma_addr_i = 32'h100; ma_mode_i = MA_LOAD;
        ma_size_i = MA_SIZE_W; wb_valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check_eq("to_req_held", {31'd0, req_a}, 32'd1);
            @(negedge clk);
        end
        check_eq("to_req", {31'd0, req_a}, 32'd0);
        check_eq("to_fault", {31'd0, fault_a}, 32'd1);
        check_eq("to_wbv", {31'd0, wb_valid_a}, 32'd0);
        check_eq("to_ready", {31'd0, ready_a}, 32'd1);
        check_eq("to_pc", pc_a, 32'h0000_3000);
        ack_a = 1'b1; rdata_a = 32'hDEAD_BEEF;
        @(negedge clk);
        ack_a = 1'b0;
        check_eq("late_ack_req", {31'd0, req_a}, 32'd0);
        check_eq("late_ack_wbv", {31'd0, wb_valid_a}, 32'd0);
        check_eq("late_ack_fault", {31'd0, fault_a}, 32'd0);

        // Reset while the second beat is outstanding.
        valid_i = 1'b1; pc_i = 32'h0000_4000; ma_addr_i = 32'h203; ma_mode_i = MA_LOAD;
        ma_size_i = MA_SIZE_H; wb_valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        ack_a = 1'b1; rdata_a = rd_word(32'h200);
        @(negedge clk);
        ack_a = 1'b0;
        check_eq("r1_req", {31'd0, req_a}, 32'd1);
        check_eq("r1_addr", addr_a, 32'h204);
        reset_i = 1'b1;
        #1 check_eq("rst_drop_req", {31'd0, req_a}, 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        check_reset_values("midrst");
        alu_op(32'h0000_5000, 32'h0020_0113, 32'hCAFE_F00D, 1'b1);

        // Randomized mix.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                alu_op($urandom | 32'h1, $urandom, $urandom, 1'($urandom));
            end else begin
                mem_op(($urandom_range(0, 1) == 0) ? MA_LOAD : MA_STORE,
                       ma_size_t'($urandom_range(0, 2)), 1'($urandom),
                       32'($urandom_range(0, 1015)), $urandom, 1'($urandom),
                       $urandom | 32'h1, 3);
            end
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                check_eq("idle_bubble", {31'd0, wb_valid_a}, 32'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
